// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READ, S_DONE
    } sa_state_e;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Width needed to index v items; never below 1 so single-entry selects stay legal.
    function automatic int sa_clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DW-wide shift register of depth D with synchronous clear; one per array edge lane.
module sa_skew_line #(
    parameter int DW = 32,
    parameter int D  = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [D-1:0][DW-1:0] sr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
    end

    assign dout = sr[D-1];

endmodule

// File: rtl/sa_sequencer.sv
// Sequences one NxN matmul on the PE grid: clear, feed, drain, read out, done.
// Define SA_SKEW_EN for a diagonally skewed operand wavefront (F = 2N-1 feed cycles).
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DRAIN = 6
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [sa_clog2(N)-1:0] k_idx,
    input  logic [N*DW-1:0]        a_col,
    input  logic [N*DW-1:0]        b_row,
    output logic [N*DW-1:0]        left_bus,
    output logic [N*DW-1:0]        top_bus,
    output logic                   arr_clr_n,
    output logic [sa_clog2(N)-1:0] res_row,
    output logic                   res_valid
);

    localparam int KW = sa_clog2(N);
`ifdef SA_SKEW_EN
    localparam bit SKEW = 1'b1;
    localparam int F    = 2*N - 1;
`else
    localparam bit SKEW = 1'b0;
    localparam int F    = N;
`endif
    localparam int CW = sa_clog2(F + DRAIN + N + 1);

    sa_state_e         state;
    logic [CW-1:0]     cnt;
    logic              feed_now;
    logic              clr;

    assign feed_now = (state == S_FEED) && (cnt < CW'(N));
    assign clr      = (state == S_CLEAR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            k_idx     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_clr_n <= 1'b1;
            res_row   <= '0;
            res_valid <= 1'b0;
        end else begin
            done      <= 1'b0;
            arr_clr_n <= 1'b1;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_CLEAR;
                    busy      <= 1'b1;
                    arr_clr_n <= 1'b0;
                    k_idx     <= '0;
                end
                S_CLEAR: begin
                    state <= S_FEED;
                    cnt   <= '0;
                    k_idx <= '0;
                end
                S_FEED: if (cnt == CW'(F - 1)) begin
                    state <= S_DRAIN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    // k_idx tracks the feed counter, then parks on the last operand
                    if (cnt < CW'(N - 1)) k_idx <= KW'(cnt + 1'b1);
                end
                S_DRAIN: if (cnt == CW'(DRAIN - 1)) begin
                    state     <= S_READ;
                    cnt       <= '0;
                    res_row   <= '0;
                    res_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_READ: if (res_row == KW'(N - 1)) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    res_row   <= res_row + 1'b1;
                    res_valid <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int D = SKEW ? i + 1 : 1;
        logic [DW-1:0] a_in, b_in;

        assign a_in = feed_now ? a_col[i*DW +: DW] : DW'(FP_ZERO);
        assign b_in = feed_now ? b_row[i*DW +: DW] : DW'(FP_ZERO);

        sa_skew_line #(.DW(DW), .D(D)) u_left (
            .CLK(CLK), .RST_N(RST_N), .clr(clr), .din(a_in), .dout(left_bus[i*DW +: DW])
        );
        sa_skew_line #(.DW(DW), .D(D)) u_top (
            .CLK(CLK), .RST_N(RST_N), .clr(clr), .din(b_in), .dout(top_bus[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: job-timeline model plus directed scenarios.
module tb_sa_sequencer;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DRAIN = 6;
`ifdef SA_SKEW_EN
    localparam int SK      = 1;
    localparam int EXP_LAT = 18;
    localparam int EXP_PER = 20;
    localparam logic [N*DW-1:0] PIN_TOP_C2 = {32'h0, 32'h0, 32'h0, 32'h3F800000};
    localparam logic [N*DW-1:0] PIN_TOP_C5 = {32'h40800000, 32'h40E00000, 32'h41200000, 32'h41500000};
`else
    localparam int SK      = 0;
    localparam int EXP_LAT = 15;
    localparam int EXP_PER = 17;
    localparam logic [N*DW-1:0] PIN_TOP_C2 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [N*DW-1:0] PIN_TOP_C5 = {32'h41800000, 32'h41700000, 32'h41600000, 32'h41500000};
`endif
    localparam int F  = SK ? 2*N - 1 : N;
    localparam int R0 = 1 + F + DRAIN;   // first READ cycle, counted from the CLEAR cycle
    localparam int T  = R0 + N;          // DONE cycle

    logic            CLK = 1'b0, RST_N = 1'b0, start = 1'b0;
    logic            busy, done, arr_clr_n, res_valid;
    logic [1:0]      k_idx, res_row;
    logic [N*DW-1:0] a_col, b_row, left_bus, top_bus;

    logic [31:0] A [N][N];
    logic [31:0] B [N][N];
    logic [31:0] FPV [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, clr_cnt = 0;
    int done_cyc_q[$];

    sa_sequencer #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .done(done),
        .k_idx(k_idx), .a_col(a_col), .b_row(b_row), .left_bus(left_bus),
        .top_bus(top_bus), .arr_clr_n(arr_clr_n), .res_row(res_row), .res_valid(res_valid)
    );

    always #5 CLK = ~CLK;

    // Operand buffers: combinational reads addressed by k_idx
    always_comb begin
        a_col = '0;
        b_row = '0;
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = A[i][k_idx];
            b_row[i*DW +: DW] = B[k_idx][i];
        end
    end

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: c = cycles since the edge that accepted start (c=0 is the CLEAR cycle)
    int c = 0;
    bit active = 0, fresh = 1;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active = 0; fresh = 1; c = 0;
        end else if ((!active || c > T) && start) begin
            active = 1; fresh = 0; c = 0;
        end else if (active && c <= T) begin
            c = c + 1;
        end
    end

    function automatic logic [N*DW-1:0] exp_bus(input bit left);
        logic [N*DW-1:0] v;
        int t;
        v = '0;
        for (int i = 0; i < N; i++) begin
            t = c - 2 - (SK ? i : 0);
            if (active && t >= 0 && t < N) v[i*DW +: DW] = left ? A[i][t] : B[t][i];
        end
        return v;
    endfunction

    always @(negedge CLK) begin
        int ek;
        cyc++;
        if (done) begin done_cnt++; done_cyc_q.push_back(cyc); end
        if (!arr_clr_n) clr_cnt++;
        chk("busy",      busy,      (active && c <= T) ? 1 : 0);
        chk("done",      done,      (active && c == T) ? 1 : 0);
        chk("arr_clr_n", arr_clr_n, (active && c == 0) ? 0 : 1);
        chk("res_valid", res_valid, (active && c >= R0 && c < T) ? 1 : 0);
        if (active && c >= R0 && c < T) chk("res_row", res_row, c - R0);
        else if (fresh)                 chk("res_row", res_row, 0);
        if (fresh) chk("k_idx", k_idx, 0);
        else if (active && c <= F) begin
            ek = (c == 0) ? 0 : ((c - 1 < N - 1) ? c - 1 : N - 1);
            chk("k_idx", k_idx, ek);
        end
        chk("left_bus", left_bus, exp_bus(1));
        chk("top_bus",  top_bus,  exp_bus(0));
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #2; end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin tick(1); k++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int off, d0, cl0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = (i == j) ? FPV[0] : 32'h0;
                B[i][j] = FPV[i*N + j];
            end

        // Reset and idle
        tick(3); RST_N = 1'b1; tick(10);
        chk("idle_busy", busy, 0);
        chk("idle_clr_n", arr_clr_n, 1);

        // Identity A, B = 1..16, with literal pins on timing and data
        pulse_start();
        @(negedge CLK); chk("pin_clr_low", arr_clr_n, 0);
        @(negedge CLK); chk("pin_k0", k_idx, 0);
        @(negedge CLK); chk("pin_top_c2", top_bus, PIN_TOP_C2);
                        chk("pin_left_c2", left_bus, {32'h0, 32'h0, 32'h0, 32'h3F800000});
        repeat (3) @(negedge CLK);
        chk("pin_top_c5", top_bus, PIN_TOP_C5);
        off = -1;
        for (int k = 6; k <= 40; k++) begin
            @(negedge CLK);
            if (done) begin off = k; break; end
        end
        chk("pin_latency", off, EXP_LAT);
        tick(2); wait_idle();

        // start held high: back-to-back jobs with one IDLE cycle between
        done_cyc_q.delete();
        start = 1'b1;
        for (int k = 0; k < 100 && done_cyc_q.size() < 3; k++) @(negedge CLK);
        start = 1'b0;
        chk("b2b_count", done_cyc_q.size(), 3);
        if (done_cyc_q.size() == 3) begin
            chk("b2b_period0", done_cyc_q[1] - done_cyc_q[0], EXP_PER);
            chk("b2b_period1", done_cyc_q[2] - done_cyc_q[1], EXP_PER);
        end
        tick(2); wait_idle(); tick(2);

        // start pulses during FEED and READ are ignored
        d0 = done_cnt;
        pulse_start(); tick(3); pulse_start();
        for (int k = 0; k < 40 && !res_valid; k++) tick(1);
        chk("read_reached", res_valid, 1);
        pulse_start();
        tick(T + 6);
        chk("ignored_start_dones", done_cnt - d0, 1);

        // Reset mid-DRAIN discards the job
        d0 = done_cnt;
        pulse_start(); tick(F + 1);
        RST_N = 1'b0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_left", left_bus, '0);
        chk("rst_top", top_bus, '0);
        tick(1); RST_N = 1'b1;
        tick(T + 5);
        chk("rst_no_done", done_cnt - d0, 0);
        pulse_start(); tick(T + 4);
        chk("rst_restart_done", done_cnt - d0, 1);

        // Zero A, random B: single clear pulse per job
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                A[i][j] = 32'h0;
                B[i][j] = $urandom;
            end
        d0 = done_cnt; cl0 = clr_cnt;
        pulse_start(); tick(T + 4);
        chk("zero_clr_pulses", clr_cnt - cl0, 1);
        chk("zero_done", done_cnt - d0, 1);

        chk("total_dones", done_cnt, 7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
